// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared defaults and FSM state encoding for the SRAM host controller
package sram_pkg;

  localparam int ROWS_DEF = 16;
  localparam int COLS_DEF = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SHIFT = 3'd1,
    WRITE = 3'd2,
    READ  = 3'd3,
    RESP  = 3'd4
  } state_t;

endpackage

// File: rtl/sram_ser.sv
// rtl/sram_ser.sv - MSB-first bit serializer with per-bit hold counter
module sram_ser #(
  parameter int COLS     = 8,
  parameter int BIT_HOLD = 2
) (
  input  logic            clk,
  input  logic            arst_n,
  input  logic            start,
  input  logic [COLS-1:0] word,
  output logic            serial_in,
  output logic            shift,
  output logic            done
);

  localparam int HW = (BIT_HOLD > 1) ? $clog2(BIT_HOLD) : 1;
  localparam int BW = (COLS > 1) ? $clog2(COLS) : 1;

  logic [HW-1:0]   hold_cnt;
  logic [BW-1:0]   bit_cnt;
  logic [COLS-1:0] sreg;
  logic            slot_end;

  assign slot_end = (hold_cnt == HW'(BIT_HOLD - 1));
  // done marks the final cycle of the final slot so the caller can register w_en on the same edge shift drops
  assign done     = shift && slot_end && (bit_cnt == BW'(COLS - 1));

  // Load the word on start, then walk slots; serial_in always presents the top bit of the remaining word
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      sreg      <= '0;
      serial_in <= 1'b0;
      shift     <= 1'b0;
      hold_cnt  <= '0;
      bit_cnt   <= '0;
    end else if (start) begin
      sreg      <= word;
      serial_in <= word[COLS-1];
      shift     <= 1'b1;
      hold_cnt  <= '0;
      bit_cnt   <= '0;
    end else if (shift) begin
      if (slot_end) begin
        hold_cnt <= '0;
        if (done) begin
          shift     <= 1'b0;
          serial_in <= 1'b0;
          bit_cnt   <= '0;
        end else begin
          bit_cnt   <= bit_cnt + 1'b1;
          sreg      <= {sreg[COLS-2:0], 1'b0};
          serial_in <= sreg[COLS-2];
        end
      end else begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sram_host_ctrl.sv
// rtl/sram_host_ctrl.sv - host request/response front end driving a serially loaded SRAM array
module sram_host_ctrl
  import sram_pkg::*;
#(
  parameter int ROWS       = ROWS_DEF,
  parameter int COLS       = COLS_DEF,
  parameter int BIT_HOLD   = 2,
  parameter int RD_TIMEOUT = 15,
  localparam int AW        = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic            clk,
  input  logic            arst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [AW-1:0]   req_addr,
  input  logic [COLS-1:0] req_wdata,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [COLS-1:0] rsp_rdata,
  output logic            rsp_err,
  output logic            serial_in,
  output logic            shift,
  output logic            w_en,
  output logic            r_en,
  output logic [AW-1:0]   addr,
  input  logic            data_valid,
  input  logic [COLS-1:0] data_out
);

  localparam int TW = $clog2(RD_TIMEOUT + 1);

  state_t        state;
  logic [TW-1:0] tcnt;
  logic          accept;
  logic          ser_done;

  assign accept = (state == IDLE) && req_valid && req_ready;

  sram_ser #(
    .COLS     (COLS),
    .BIT_HOLD (BIT_HOLD)
  ) u_ser (
    .clk       (clk),
    .arst_n    (arst_n),
    .start     (accept && req_write),
    .word      (req_wdata),
    .serial_in (serial_in),
    .shift     (shift),
    .done      (ser_done)
  );

  // Request sequencing: accept, shift/write or read-with-timeout, then hold the response until taken
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state     <= IDLE;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      w_en      <= 1'b0;
      r_en      <= 1'b0;
      addr      <= '0;
      tcnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (accept) begin
            req_ready <= 1'b0;
            addr      <= req_addr;
            tcnt      <= '0;
            if (req_write) begin
              state <= SHIFT;
            end else begin
              state <= READ;
              r_en  <= 1'b1;
            end
          end
        end
        SHIFT: begin
          if (ser_done) begin
            state <= WRITE;
            w_en  <= 1'b1;
          end
        end
        WRITE: begin
          w_en      <= 1'b0;
          state     <= RESP;
          rsp_valid <= 1'b1;
          rsp_rdata <= '0;
          rsp_err   <= 1'b0;
        end
        READ: begin
          // Data arriving on the last allowed cycle still wins over the timeout
          if (data_valid) begin
            r_en      <= 1'b0;
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= data_out;
            rsp_err   <= 1'b0;
          end else if (tcnt == TW'(RD_TIMEOUT - 1)) begin
            r_en      <= 1'b0;
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
            req_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_host_ctrl.sv
// tb/tb_sram_host_ctrl.sv - randomized self-checking bench with an SRAM array model and scoreboard
module tb_sram_host_ctrl;

  localparam int ROWS       = 16;
  localparam int COLS       = 8;
  localparam int BIT_HOLD   = 2;
  localparam int RD_TIMEOUT = 15;
  localparam int AW         = 4;
  localparam int NB         = COLS * BIT_HOLD;

  logic            clk;
  logic            arst_n;
  logic            req_valid, req_ready, req_write;
  logic [AW-1:0]   req_addr;
  logic [COLS-1:0] req_wdata;
  logic            rsp_valid, rsp_ready, rsp_err;
  logic [COLS-1:0] rsp_rdata;
  logic            serial_in, shift, w_en, r_en;
  logic [AW-1:0]   addr;
  logic            data_valid = 1'b0;
  logic [COLS-1:0] data_out   = '0;
  logic [18:0]     outv;

  assign outv = {req_ready, rsp_valid, rsp_rdata, rsp_err, serial_in, shift, w_en, r_en, addr};

  sram_host_ctrl #(
    .ROWS       (ROWS),
    .COLS       (COLS),
    .BIT_HOLD   (BIT_HOLD),
    .RD_TIMEOUT (RD_TIMEOUT)
  ) dut (
    .clk        (clk),
    .arst_n     (arst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .serial_in  (serial_in),
    .shift      (shift),
    .w_en       (w_en),
    .r_en       (r_en),
    .addr       (addr),
    .data_valid (data_valid),
    .data_out   (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // SRAM array model and host-side scoreboard
  logic [COLS-1:0] mem     [ROWS];
  logic [COLS-1:0] ref_mem [ROWS];
  logic [COLS-1:0] sh_word = '0;
  int              sk = 0;
  int              rk = 0;
  int              rd_delay = 0;
  bit              rd_never = 0;
  bit              noise    = 0;

  // Array model: assembles shifted bits, stores on w_en, answers r_en after rd_delay cycles
  always @(negedge clk) begin
    if (shift) begin
      sk++;
      if (sk % BIT_HOLD == 0) sh_word = {sh_word[COLS-2:0], serial_in};
    end else begin
      sk = 0;
    end
    if (w_en) mem[addr] = sh_word;
    if (r_en) begin
      rk++;
      data_valid = !rd_never && (rk == rd_delay + 1);
      data_out   = data_valid ? mem[addr] : COLS'($urandom);
    end else begin
      rk = 0;
      data_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      data_out   = COLS'($urandom);
    end
  end

  function automatic logic [NB-1:0] expand(input logic [COLS-1:0] d);
    logic [NB-1:0] r = '0;
    for (int k = 0; k < NB; k++) r = {r[NB-2:0], d[COLS-1-k/BIT_HOLD]};
    return r;
  endfunction

  task automatic run_txn(input logic wr, input logic [AW-1:0] a, input logic [COLS-1:0] d,
                         input int hold, input int dly, input bit never);
    int              wait_n = 0, shift_n = 0, ren_n = 0, wen_n = 0, wen_c = 0, rsp_c = 0;
    int              exp_ren, exp_rsp;
    logic [AW-1:0]   wen_a = '0;
    logic [NB-1:0]   sbits = '0;
    logic [COLS-1:0] exp_data;
    logic            exp_err;
    bit              ovl = 0, addr_bad = 0, unstable = 0;
    logic [COLS+1:0] snap;
    while (!req_ready && wait_n < 50) begin
      @(negedge clk);
      wait_n++;
    end
    check("req_ready_wait", 32'(req_ready), 32'(1));
    if (!req_ready) return;
    rd_delay  = dly;
    rd_never  = never;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (c == 1) req_valid = 1'b0;
      if (shift) begin
        shift_n++;
        sbits = {sbits[NB-2:0], serial_in};
      end
      if (w_en) begin
        wen_n++;
        wen_c = c;
        wen_a = addr;
      end
      if (r_en) begin
        ren_n++;
        if (addr !== a) addr_bad = 1;
      end
      if (int'(shift) + int'(w_en) + int'(r_en) > 1) ovl = 1;
      if (rsp_valid) begin
        rsp_c = c;
        break;
      end
    end
    check("rsp_seen", 32'(rsp_c != 0), 32'(1));
    if (rsp_c == 0) return;
    if (wr) begin
      exp_ren = 0; exp_rsp = NB + 2; exp_data = '0; exp_err = 1'b0;
    end else if (!never && dly + 1 <= RD_TIMEOUT) begin
      exp_ren = dly + 1; exp_rsp = dly + 2; exp_data = ref_mem[a]; exp_err = 1'b0;
    end else begin
      exp_ren = RD_TIMEOUT; exp_rsp = RD_TIMEOUT + 1; exp_data = '0; exp_err = 1'b1;
    end
    check("rsp_cycle", 32'(rsp_c), 32'(exp_rsp));
    check("rsp_rdata", 32'(rsp_rdata), 32'(exp_data));
    check("rsp_err", 32'(rsp_err), 32'(exp_err));
    check("ren_cycles", 32'(ren_n), 32'(exp_ren));
    check("wen_count", 32'(wen_n), wr ? 32'(1) : 32'(0));
    check("shift_cycles", 32'(shift_n), wr ? 32'(NB) : 32'(0));
    check("no_overlap", 32'(ovl), 32'(0));
    check("addr_during_op", 32'(addr_bad), 32'(0));
    check("addr_in_resp", 32'(addr), 32'(a));
    if (wr) begin
      check("serial_bits", 32'(sbits), 32'(expand(d)));
      check("wen_cycle", 32'(wen_c), 32'(NB + 1));
      check("wen_addr", 32'(wen_a), 32'(a));
    end
    snap = {rsp_valid, rsp_err, rsp_rdata};
    if (hold > 0) begin
      req_valid = 1'b1;
      req_write = ~wr;
      req_addr  = ~a;
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if ({rsp_valid, rsp_err, rsp_rdata} !== snap || req_ready !== 1'b0 || shift || w_en || r_en)
        unstable = 1;
    end
    if (hold > 0) check("resp_hold_stable", 32'(unstable), 32'(0));
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_valid_drop", 32'(rsp_valid), 32'(0));
    check("ready_after_resp", 32'(req_ready), 32'(1));
    if (wr) ref_mem[a] = d;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    bit bad = 0;
    for (int i = 0; i < ROWS; i++) begin
      mem[i]     = '0;
      ref_mem[i] = '0;
    end
    arst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'(outv), 32'(0));
    arst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", 32'(req_ready), 32'(1));

    run_txn(1'b1, 4'd3, 8'hA5, 0, 0, 0);
    run_txn(1'b0, 4'd3, 8'h00, 1, 4, 0);
    run_txn(1'b0, 4'd5, 8'h00, 0, 0, 1);
    run_txn(1'b0, 4'd3, 8'h00, 10, RD_TIMEOUT - 1, 0);

    req_valid = 1'b1; req_write = 1'b1; req_addr = 4'd9; req_wdata = 8'h5A;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (c == 1) req_valid = 1'b0;
    end
    check("rst_mid_shift", 32'(shift), 32'(1));
    arst_n = 1'b0;
    #1;
    check("rst_async_outputs", 32'(outv), 32'(0));
    @(negedge clk);
    @(negedge clk);
    arst_n = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (w_en || shift || r_en) bad = 1;
    end
    check("rst_no_wen_after", 32'(bad), 32'(0));
    check("rst_ready", 32'(req_ready), 32'(1));
    run_txn(1'b1, 4'd9, 8'h3C, 0, 0, 0);
    run_txn(1'b0, 4'd9, 8'h00, 2, 2, 0);

    noise = 1;
    for (int i = 0; i < ROWS; i++)
      run_txn(1'b1, AW'(i), COLS'($urandom), $urandom_range(0, 3), 0, 0);
    for (int i = 0; i < ROWS; i++)
      run_txn(1'b0, AW'(i), 8'h00, $urandom_range(0, 3), $urandom_range(0, RD_TIMEOUT - 1), 0);
    run_txn(1'b0, AW'($urandom), 8'h00, 1, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sram_host_ctrl.md
SRAM_HOST_CTRL -- requirements
Module: sram_host_ctrl

Interface
REQ-001 The block SHALL have parameter ROWS, default 16: SRAM word count; addr width is $clog2(ROWS).
REQ-002 The block SHALL have parameter COLS, default 8: SRAM word width in bits.
REQ-003 The block SHALL have parameter BIT_HOLD, default 2: clock cycles each serial bit and shift are held.
REQ-004 The block SHALL have parameter RD_TIMEOUT, default 15: maximum r_en cycles waiting for data_valid.
REQ-005 The block SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-006 The block SHALL have port arst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-007 The block SHALL have port req_valid, input, 1 bit: host request present.
REQ-008 The block SHALL have port req_ready, output, 1 bit: block accepts a request.
REQ-009 The block SHALL have port req_write, input, 1 bit: 1 means write, 0 means read.
REQ-010 The block SHALL have port req_addr, input, $clog2(ROWS) bits: target row.
REQ-011 The block SHALL have port req_wdata, input, COLS bits: write word.
REQ-012 The block SHALL have port rsp_valid, output, 1 bit: response present.
REQ-013 The block SHALL have port rsp_ready, input, 1 bit: host takes the response.
REQ-014 The block SHALL have port rsp_rdata, output, COLS bits: read word, 0 for writes and errors.
REQ-015 The block SHALL have port rsp_err, output, 1 bit: read timeout flag.
REQ-016 The block SHALL have SRAM-side outputs serial_in (1), shift (1), w_en (1), r_en (1) and addr ($clog2(ROWS)), all driving the SRAM array.
REQ-017 The block SHALL have SRAM-side inputs data_valid (1) and data_out (COLS), both from the SRAM array.

Function
REQ-018 The block SHALL implement an FSM with states IDLE, SHIFT, WRITE, READ and RESP; all outputs SHALL be registered.
REQ-019 req_ready SHALL be 1 only in IDLE; a request is accepted on the cycle with req_valid && req_ready, and addr, word and kind are captured.
REQ-020 When a write is accepted, the FSM SHALL go IDLE->SHIFT and drive shift=1 for exactly COLS*BIT_HOLD consecutive cycles starting the cycle after accept.
REQ-021 In SHIFT, serial_in SHALL carry word[COLS-1-k] during the k-th BIT_HOLD-cycle slot, MSB first, each bit stable for BIT_HOLD cycles.
REQ-022 After the last slot, the FSM SHALL enter WRITE and drive w_en=1 for exactly one cycle (shift=0, addr valid), then go to RESP with rsp_err=0 and rsp_rdata=0.
REQ-023 Write latency SHALL be: accept at cycle 0, w_en at cycle COLS*BIT_HOLD+1, rsp_valid from cycle COLS*BIT_HOLD+2.
REQ-024 When a read is accepted, the FSM SHALL go IDLE->READ and hold r_en=1 with addr from the cycle after accept.
REQ-025 In READ, the first cycle with data_valid=1 SHALL capture data_out into rsp_rdata, deassert r_en next cycle and go to RESP with rsp_err=0.
REQ-026 If RD_TIMEOUT r_en cycles elapse without data_valid, the block SHALL go to RESP with rsp_err=1 and rsp_rdata=0.
REQ-027 If data_valid arrives on the timeout cycle itself, data SHALL win and rsp_err=0.
REQ-028 In RESP, rsp_valid SHALL be held with stable data until rsp_ready=1; on that cycle the FSM returns to IDLE, and req_ready is 1 the following cycle.
REQ-029 data_valid outside READ SHALL be ignored.
REQ-030 shift, w_en and r_en SHALL be mutually exclusive in every cycle.
REQ-031 addr SHALL hold the captured address from accept until return to IDLE.

Reset
REQ-032 On arst_n=0, the block SHALL immediately enter IDLE and set req_ready=0 (1 from the first clock after release), rsp_valid=0, rsp_rdata=0, rsp_err=0, serial_in=0, shift=0, w_en=0, r_en=0, addr=0, and clear all counters.
REQ-033 Reset mid-SHIFT or mid-READ SHALL abandon the operation; no w_en SHALL follow reset release.

Structure
REQ-034 ROWS/COLS defaults and the state enum (IDLE, SHIFT, WRITE, READ, RESP) SHALL live in package sram_pkg.
REQ-035 The bit-slot/hold counter and MSB-first selection SHALL be a sub-module sram_ser, with a start input, a done output, and serial_in/shift outputs.

Verification
REQ-036 Write of addr=3, wdata=8'hA5 -> shift high for 16 cycles; serial_in bits 1,0,1,0,0,1,0,1 each held 2 cycles; w_en for 1 cycle at cycle 17 with addr=3; rsp_valid with err=0.
REQ-037 Read of addr=3, model data_valid 4 cycles after r_en with data_out=8'hA5 -> rsp_rdata=8'hA5, rsp_err=0, r_en low the cycle after capture.
REQ-038 Read with data_valid never asserted -> exactly 15 r_en cycles, then rsp_err=1 and rsp_rdata=0.
REQ-039 rsp_ready held low for 10 cycles -> rsp_valid and data stable throughout; req_ready stays 0; a new req_valid is not accepted.
REQ-040 arst_n pulsed low at shift cycle 7 of a write -> all outputs 0 at once; no w_en afterwards; a fresh write of 8'h3C completes correctly.
REQ-041 Back-to-back writes to addr 0..15 with data_valid toggled randomly -> no w_en/r_en/shift overlap; a read-back of all 16 rows matches.
